// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the NPC load/store initiator:
// access size encodings, FSM state type and the alignment check.
package npc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

  // Naturally aligned accesses only; bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: write mask, store data lane shift,
// and load data shift with sign/zero extension.
module lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic [2:0]      off,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext
);

  logic [5:0]      sh_amt;
  logic [XLEN-1:0] rdata_sh;

  always_comb begin
    sh_amt   = {off, 3'b000};
    wdata_sh = wdata << sh_amt;
    rdata_sh = rdata >> sh_amt;

    case (size)
      SZ_B:    wmask = 8'h01 << off;
      SZ_H:    wmask = 8'h03 << off;
      SZ_W:    wmask = 8'h0F << off;
      default: wmask = 8'hFF;
    endcase

    rdata_ext = rdata_sh;
    case (size)
      SZ_B: rdata_ext = is_unsigned ? {{(XLEN-8){1'b0}}, rdata_sh[7:0]}
                                    : {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H: rdata_ext = is_unsigned ? {{(XLEN-16){1'b0}}, rdata_sh[15:0]}
                                    : {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      SZ_W: rdata_ext = is_unsigned ? {{(XLEN-32){1'b0}}, rdata_sh[31:0]}
                                    : {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between EXU and the data-memory blackbox: one request
// in flight, fixed-latency memory access, registered response.
//
// state  | meaning
// IDLE   | ready for a request; accepted requests are latched here
// ACCESS | memory strobes active for MEM_LAT cycles; cnt counts down to 0
// DONE   | response held until the consumer takes it
module lsu_mem_initiator
  import npc_lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_raddr,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  output logic            mem_write
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  lsu_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic [XLEN-1:0] word_addr;

  // Align unit sees only latched request fields, so mem_* never depend on req_*.
  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size        (size_q),
    .off         (addr_q[2:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .wmask       (al_wmask),
    .wdata_sh    (al_wdata),
    .rdata_ext   (al_rdata)
  );

  assign word_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wmask  = 8'h00;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (is_misaligned(req_size, req_addr[2:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        mem_raddr = word_addr;
        mem_waddr = word_addr;
        mem_wdata = al_wdata;
        mem_wmask = wen_q ? al_wmask : 8'h00;
        mem_read  = ~wen_q;
        // Single write strobe, issued on the final access cycle.
        mem_write = wen_q && (cnt_q == 4'd0);
        if (cnt_q == 4'd0) begin
          rdata_d = wen_q ? '0 : al_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives the core's DPI-backed data-memory port: mem_raddr, mem_read, mem_waddr, mem_wdata, mem_wmask, mem_write and mem_rdata.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Aligns addresses to 8-byte words and generates byte write masks.
- Shifts and sign/zero-extends load data.
- Returns a registered response over a second valid/ready handshake.
- Sits between EXU and the memory blackbox in the NPC.

Parameters:
- MEM_LAT, 1: cycles spent in ACCESS per request (range 1..15); models memory latency.
- XLEN, 64: data/address width; only 64 is supported.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept a request.
- req_addr  in  64  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend the load result; ignored for stores and for dword.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  64  extended load data; 0 for stores and on error.
- resp_err  out  1  misaligned access.
- mem_raddr  out  64  8-byte-aligned read address.
- mem_read  out  1  read strobe.
- mem_rdata  in  64  read data; combinational in the same cycle as mem_read.
- mem_waddr  out  64  8-byte-aligned write address.
- mem_wdata  out  64  lane-shifted write data.
- mem_wmask  out  8  byte-lane mask.
- mem_write  out  1  write strobe.

Behaviour:
- Reset is synchronous: when rst_n is low at a clk edge, the state goes to IDLE.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_wmask=0, addresses=0, mem_wdata=0.
  - A reset in ACCESS or DONE aborts the request silently. No write strobe is issued after the reset edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wen, size, unsigned and wdata.
  - Compute off=addr[2:0].
  - Misaligned means: size=1 and addr[0]!=0; size=2 and addr[1:0]!=0; size=3 and addr[2:0]!=0.
  - If misaligned: go to DONE with err=1 and rdata=0. No memory strobe is ever asserted.
  - Otherwise: go to ACCESS and load cnt=MEM_LAT-1.
- ACCESS:
  - req_ready=0.
  - mem_raddr = mem_waddr = {addr[63:3],3'b000}.
  - Load: mem_read=1 on every ACCESS cycle. mem_rdata is sampled at the edge where cnt==0.
  - Store: mem_write=1 only in the cycle where cnt==0, so exactly one write strobe is issued per store.
  - mem_wmask: size 0 gives 8'h01<<off, size 1 gives 8'h03<<off, size 2 gives 8'h0F<<off, size 3 gives 8'hFF.
  - mem_wdata = req_wdata<<(off*8). Upper bits of wdata beyond the size are don't-care and are masked by mem_wmask.
  - cnt decrements each cycle. When cnt==0, go to DONE.
  - Latency from accept edge to resp_valid=1 is MEM_LAT+1 cycles.
- DONE:
  - resp_valid=1; rdata and err are held stable while resp_valid=1&&resp_ready=0.
  - Load data: shifted = mem_rdata>>(off*8), truncated to the size.
  - Extension: sign-extend from bit 7, 15 or 31, unless req_unsigned is set, in which case zero-extend.
  - Stores return resp_rdata=0.
  - On resp_ready, go to IDLE.
  - A new request is not accepted in the same cycle as the handoff. req_ready is 1 only in IDLE, giving a minimum of MEM_LAT+2 cycles per request.
- Strobes in IDLE and DONE: mem_read=0, mem_write=0, mem_wmask=0.
- mem_* outputs are decoded from registered state only. There is no combinational path from req_* to mem_*.
- req_valid is ignored outside IDLE.

Decomposition:
- Package npc_lsu_pkg holds:
  - the size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2, SZ_D=2'd3;
  - the FSM state enum (IDLE, ACCESS, DONE);
  - a misalign-check function.
- One combinational sub-module, lsu_align, contains:
  - the wmask generator;
  - the write-data shifter;
  - the load shift/extend logic.
- The FSM, counter and latches stay in lsu_mem_initiator.

Test Plan:
- Preload word 0x1000 = 64'h8877_6655_4433_2211. Load byte, signed, at 0x1007 -> mem_raddr=0x1000; resp_rdata=64'hFFFF_FFFF_FFFF_FF88; resp_err=0; resp_valid rises 2 cycles after accept (MEM_LAT=1).
- Same word. Load half, unsigned, at 0x1002 -> resp_rdata=64'h0000_0000_0000_4433. Load word, signed, at 0x1004 -> 64'hFFFF_FFFF_8877_6655.
- Store half, wdata 64'hABCD, at 0x2006 -> exactly one cycle with mem_write=1, mem_waddr=0x2000, mem_wmask=8'hC0, mem_wdata[63:48]=16'hABCD; resp_rdata=0.
- Load dword at 0x3004 -> resp_err=1, resp_rdata=0; mem_read and mem_write stay 0 throughout.
- MEM_LAT=3, load with resp_ready held 0 for 5 cycles -> mem_read high for 3 cycles; resp_valid and resp_rdata stable for all 5 cycles; req_ready=0 until the cycle after the resp handshake.
- Assert rst_n=0 during ACCESS of a store with MEM_LAT=3 at cnt=1 -> no mem_write pulse; next cycle req_ready=1, resp_valid=0.
